quadrant_arbiter: RTL and testbench
===================================

QUADRANT_ARBITER -- requirements
Module: quadrant_arbiter

Interface
REQ-001 The block SHALL have parameter W, default 3, giving the coordinate width of X and Y on every port.
REQ-002 The block SHALL have parameter CW, default 8, giving the width of each served-transfer counter.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset_, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port dav0_, input, 1 bit: producer 0 data valid, active low.
REQ-006 Ports X0 and Y0, input, W bits each: producer 0 coordinates.
REQ-007 Port rfd0, output, 1 bit: ready-for-data to producer 0.
REQ-008 Port dav1_, input, 1 bit: producer 1 data valid, active low.
REQ-009 Ports X1 and Y1, input, W bits each: producer 1 coordinates.
REQ-010 Port rfd1, output, 1 bit: ready-for-data to producer 1.
REQ-011 Port dav_, output, 1 bit: data valid to the shared quadrant consumer, active low.
REQ-012 Ports X and Y, output, W bits each: coordinates to the consumer.
REQ-013 Port rfd, input, 1 bit: ready-for-data from the consumer.
REQ-014 Port gnt, output, 1 bit: index of the producer currently or last granted.
REQ-015 Port busy, output, 1 bit: 1 while a transfer is in progress.
REQ-016 Ports cnt0 and cnt1, output, CW bits each: number of completed transfers per producer.

Function
REQ-017 All outputs SHALL be registered; each handshake reaction SHALL occur on the first rising edge at which its condition is sampled true.
REQ-018 The block SHALL implement FSM states S_IDLE, S_PRES, S_REL and S_END.
REQ-019 In S_IDLE, with rfd==1 and at least one dav_i==0 sampled, the block SHALL grant one producer, latch its Xi/Yi into X/Y, set gnt, set busy=1 and dav_=0, and enter S_PRES.
REQ-020 In S_IDLE with rfd==0, the block SHALL issue no grant, regardless of the producer requests.
REQ-021 With one request, that producer SHALL win; with both, the producer with priority SHALL win; priority SHALL pass to the non-served producer after each completed transfer; priority after reset SHALL be producer 0.
REQ-022 In S_PRES, on rfd==0, the block SHALL drive rfd of the granted producer to 0 and enter S_REL; otherwise it SHALL hold.
REQ-023 In S_REL, on dav_ of the granted producer ==1, the block SHALL drive dav_=1 and enter S_END.
REQ-024 In S_END, on rfd==1, the block SHALL drive rfd of the granted producer to 1, increment that producer's counter, toggle priority, clear busy and return to S_IDLE.
REQ-025 The non-granted producer's rfd SHALL stay 1 throughout; a pending request from it SHALL remain pending and SHALL be served only after return to S_IDLE.
REQ-026 X/Y SHALL stay constant from grant until the next grant.
REQ-027 cnt0/cnt1 SHALL wrap from 2^CW-1 to 0 with no flag.
REQ-028 Input changes outside the awaited condition of the current state SHALL be ignored.
REQ-029 From dav_i sampled low in S_IDLE to dav_ low SHALL be 1 clock; a full transfer SHALL be at least 4 clocks.

Reset
REQ-030 While reset_==0, the block SHALL immediately force: state S_IDLE, dav_=1, rfd0=rfd1=1, X=Y=0, gnt=0, busy=0, cnt0=cnt1=0, priority to producer 0.
REQ-031 Reset mid-transfer SHALL abandon the transfer without a counter increment; after release, a producer still holding dav_i=0 SHALL be re-arbitrated normally.

Verification
REQ-032 Reset: assert reset_=0 mid-S_REL -> outputs immediately dav_=1, rfd0=rfd1=1, cnt0=cnt1=0, busy=0.
REQ-033 Single producer: dav0_=0, X0=3'b111, Y0=3'b001, rfd=1 -> next edge dav_=0, X=7, Y=1, gnt=0; consumer completes the handshake -> cnt0=1, rfd0 back to 1.
REQ-034 Simultaneous requests: dav0_=dav1_=0 after reset -> producer 0 served first, then producer 1 without interleaving, with rfd1 held at 1 during producer 0's transfer; cnt0=1, cnt1=1.
REQ-035 Fairness: both producers request continuously for 6 transfers -> gnt sequence 0,1,0,1,0,1; cnt0=3, cnt1=3.
REQ-036 Consumer not ready: rfd=0 while dav1_=0 -> no grant and dav_ stays 1; rfd=1 -> grant 1 on the next edge.
REQ-037 Wrap: CW=2 with 5 transfers from producer 0 only -> cnt0 sequence 1,2,3,0,1.

Source files
------------

// File: rtl/quadrant_arbiter.sv
// Two-producer, one-consumer arbiter for the quadrant bus: four-phase
// dav_/rfd handshake, alternating priority, registered outputs, per-producer transfer counters.

module qa_counter #(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic          inc,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge clock or negedge reset_)
    if (!reset_)  cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
endmodule

module quadrant_arbiter #(
  parameter int W  = 3,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset_,
  input  logic          dav0_,
  input  logic [W-1:0]  X0,
  input  logic [W-1:0]  Y0,
  output logic          rfd0,
  input  logic          dav1_,
  input  logic [W-1:0]  X1,
  input  logic [W-1:0]  Y1,
  output logic          rfd1,
  output logic          dav_,
  output logic [W-1:0]  X,
  output logic [W-1:0]  Y,
  input  logic          rfd,
  output logic          gnt,
  output logic          busy,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);
  localparam int NP = 2;

  typedef enum logic [1:0] {S_IDLE, S_PRES, S_REL, S_END} state_t;

  state_t                  state, state_nxt;
  logic [W-1:0]            x_q, y_q, x_nxt, y_nxt;
  logic                    gnt_q, gnt_nxt, busy_q, busy_nxt, dav_q, dav_nxt;
  logic                    prio_q, prio_nxt, sel;
  logic [NP-1:0]           rfd_q, rfd_nxt, inc, req, dav_in;
  logic [NP-1:0][CW-1:0]   cnt_a;

  assign dav_in = {dav1_, dav0_};
  assign req    = ~dav_in;
  // Contention goes to the priority holder; a lone request always wins.
  assign sel    = (&req) ? prio_q : req[1];

  always_comb begin
    state_nxt = state;
    x_nxt     = x_q;
    y_nxt     = y_q;
    gnt_nxt   = gnt_q;
    busy_nxt  = busy_q;
    dav_nxt   = dav_q;
    prio_nxt  = prio_q;
    rfd_nxt   = rfd_q;
    inc       = '0;
    case (state)
      S_IDLE: if (rfd && |req) begin
        x_nxt     = sel ? X1 : X0;
        y_nxt     = sel ? Y1 : Y0;
        gnt_nxt   = sel;
        busy_nxt  = 1'b1;
        dav_nxt   = 1'b0;
        state_nxt = S_PRES;
      end
      S_PRES: if (!rfd) begin
        rfd_nxt[gnt_q] = 1'b0;
        state_nxt      = S_REL;
      end
      S_REL: if (dav_in[gnt_q]) begin
        dav_nxt   = 1'b1;
        state_nxt = S_END;
      end
      S_END: if (rfd) begin
        rfd_nxt[gnt_q] = 1'b1;
        inc[gnt_q]     = 1'b1;
        prio_nxt       = ~gnt_q;
        busy_nxt       = 1'b0;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_)
    if (!reset_) begin
      state  <= S_IDLE;
      x_q    <= '0;
      y_q    <= '0;
      gnt_q  <= 1'b0;
      busy_q <= 1'b0;
      dav_q  <= 1'b1;
      prio_q <= 1'b0;
      rfd_q  <= '1;
    end else begin
      state  <= state_nxt;
      x_q    <= x_nxt;
      y_q    <= y_nxt;
      gnt_q  <= gnt_nxt;
      busy_q <= busy_nxt;
      dav_q  <= dav_nxt;
      prio_q <= prio_nxt;
      rfd_q  <= rfd_nxt;
    end

  for (genvar i = 0; i < NP; i++) begin : g_cnt
    qa_counter #(.CW(CW)) u_cnt (
      .clock  (clock),
      .reset_ (reset_),
      .inc    (inc[i]),
      .cnt    (cnt_a[i])
    );
  end

  assign X    = x_q;
  assign Y    = y_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign dav_ = dav_q;
  assign rfd0 = rfd_q[0];
  assign rfd1 = rfd_q[1];
  assign cnt0 = cnt_a[0];
  assign cnt1 = cnt_a[1];
endmodule

// File: tb/tb_quadrant_arbiter.sv
// Directed bench for quadrant_arbiter: default-width instance plus a CW=2
// instance on the same inputs for counter wrap.

module tb_quadrant_arbiter;
  logic       clock = 1'b0;
  logic       reset_, dav0_, dav1_, rfd;
  logic [2:0] X0, Y0, X1, Y1;
  logic       rfd0, rfd1, dav_, gnt, busy;
  logic [2:0] X, Y;
  logic [7:0] cnt0, cnt1;
  logic       w_rfd0, w_rfd1, w_dav_, w_gnt, w_busy;
  logic [2:0] w_X, w_Y;
  logic [1:0] w_cnt0, w_cnt1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt [2];

  always #5 clock = ~clock;

  quadrant_arbiter dut (
    .clock(clock), .reset_(reset_),
    .dav0_(dav0_), .X0(X0), .Y0(Y0), .rfd0(rfd0),
    .dav1_(dav1_), .X1(X1), .Y1(Y1), .rfd1(rfd1),
    .dav_(dav_), .X(X), .Y(Y), .rfd(rfd),
    .gnt(gnt), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  quadrant_arbiter #(.W(3), .CW(2)) dut_w (
    .clock(clock), .reset_(reset_),
    .dav0_(dav0_), .X0(X0), .Y0(Y0), .rfd0(w_rfd0),
    .dav1_(dav1_), .X1(X1), .Y1(Y1), .rfd1(w_rfd1),
    .dav_(w_dav_), .X(w_X), .Y(w_Y), .rfd(rfd),
    .gnt(w_gnt), .busy(w_busy), .cnt0(w_cnt0), .cnt1(w_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset_ = 1'b0;
    #2;
    reset_ = 1'b1;
    exp_cnt[0] = 8'd0;
    exp_cnt[1] = 8'd0;
    tick();
  endtask

  // One complete four-phase transfer for producer p, starting from S_IDLE
  // with its request already asserted and rfd high.
  task automatic xfer(input int p, input logic [2:0] ex, input logic [2:0] ey, input bit rereq);
    logic r_g, r_o;
    tick();
    chk("grant_dav_", dav_, 1'b0);
    chk("grant_gnt", gnt, p[0]);
    chk("grant_busy", busy, 1'b1);
    chk("grant_X", X, ex);
    chk("grant_Y", Y, ey);
    rfd = 1'b0;
    tick();
    r_g = p ? rfd1 : rfd0;
    r_o = p ? rfd0 : rfd1;
    chk("pres_rfd_granted", r_g, 1'b0);
    chk("pres_rfd_other", r_o, 1'b1);
    if (p == 0) dav0_ = 1'b1; else dav1_ = 1'b1;
    tick();
    chk("rel_dav_", dav_, 1'b1);
    rfd = 1'b1;
    tick();
    r_g = p ? rfd1 : rfd0;
    chk("end_rfd_granted", r_g, 1'b1);
    chk("end_busy", busy, 1'b0);
    exp_cnt[p] = exp_cnt[p] + 8'd1;
    chk("end_cnt0", cnt0, exp_cnt[0]);
    chk("end_cnt1", cnt1, exp_cnt[1]);
    if (rereq) begin
      if (p == 0) dav0_ = 1'b0; else dav1_ = 1'b0;
    end
  endtask

  initial begin
    reset_ = 1'b0; dav0_ = 1'b1; dav1_ = 1'b1; rfd = 1'b1;
    X0 = 3'd0; Y0 = 3'd0; X1 = 3'd0; Y1 = 3'd0;
    exp_cnt[0] = 8'd0; exp_cnt[1] = 8'd0;
    tick(); tick();
    chk("rst_dav_", dav_, 1'b1);
    chk("rst_rfd0", rfd0, 1'b1);
    chk("rst_rfd1", rfd1, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gnt", gnt, 1'b0);
    chk("rst_X", X, 3'd0);
    chk("rst_cnt0", cnt0, 8'd0);
    reset_ = 1'b1;
    tick();

    // Single producer, then coordinates must hold while idle.
    X0 = 3'b111; Y0 = 3'b001; dav0_ = 1'b0;
    xfer(0, 3'd7, 3'd1, 1'b0);
    X0 = 3'd3; Y0 = 3'd6;
    tick();
    chk("idle_X_hold", X, 3'd7);
    chk("idle_Y_hold", Y, 3'd1);
    chk("idle_no_grant", dav_, 1'b1);

    // Reset in S_REL, then re-arbitrate the still-requesting producer.
    X0 = 3'd7; Y0 = 3'd1; dav0_ = 1'b0;
    tick();
    rfd = 1'b0;
    tick();
    chk("rel_rfd0", rfd0, 1'b0);
    reset_ = 1'b0;
    #1;
    chk("midrst_dav_", dav_, 1'b1);
    chk("midrst_rfd0", rfd0, 1'b1);
    chk("midrst_rfd1", rfd1, 1'b1);
    chk("midrst_cnt0", cnt0, 8'd0);
    chk("midrst_cnt1", cnt1, 8'd0);
    chk("midrst_busy", busy, 1'b0);
    exp_cnt[0] = 8'd0; exp_cnt[1] = 8'd0;
    #1;
    reset_ = 1'b1;
    rfd = 1'b1;
    xfer(0, 3'd7, 3'd1, 1'b0);

    // Simultaneous requests after reset: 0 first, then 1.
    pulse_reset();
    X1 = 3'd2; Y1 = 3'd5;
    dav0_ = 1'b0; dav1_ = 1'b0;
    xfer(0, 3'd7, 3'd1, 1'b0);
    xfer(1, 3'd2, 3'd5, 1'b0);

    // Fairness under continuous requests.
    pulse_reset();
    dav0_ = 1'b0; dav1_ = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) xfer(0, 3'd7, 3'd1, 1'b1);
      else            xfer(1, 3'd2, 3'd5, 1'b1);
    end
    dav0_ = 1'b1; dav1_ = 1'b1;
    chk("fair_cnt0", cnt0, 8'd3);
    chk("fair_cnt1", cnt1, 8'd3);
    tick();

    // Consumer not ready blocks the grant.
    rfd = 1'b0; dav1_ = 1'b0;
    tick(); tick();
    chk("notrdy_dav_", dav_, 1'b1);
    chk("notrdy_busy", busy, 1'b0);
    rfd = 1'b1;
    xfer(1, 3'd2, 3'd5, 1'b0);

    // Counter wrap on the CW=2 instance.
    pulse_reset();
    dav0_ = 1'b0;
    for (int i = 0; i < 5; i++) begin
      xfer(0, 3'd7, 3'd1, 1'b1);
      chk("wrap_cnt0", w_cnt0, (i + 1) % 4);
      chk("wrap_cnt1", w_cnt1, 2'd0);
    end
    dav0_ = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
